// File: rtl/rf_ctrl_pkg.sv
// Shared types for the register-file write-port control slice.
// Holds datapath widths and the write-request bundle.
package rf_ctrl_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wreq_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// In-order buffer for long-latency write requests.
// Pointers wrap modulo DEPTH; push and pop may share an edge.
module rf_wb_fifo
  import rf_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  push,
  input  logic  pop,
  input  wreq_t din,
  output logic  full,
  output logic  empty,
  output wreq_t head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wreq_t          mem [DEPTH];
  logic [AW-1:0]  wp;
  logic [AW-1:0]  rp;
  logic [AW:0]    cnt;
  logic           do_push;
  logic           do_pop;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign head    = mem[rp];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= nxt(wp);
      if (do_pop)  rp <= nxt(rp);
      if (do_push && !do_pop)
        cnt <= cnt + 1'b1;
      else if (do_pop && !do_push)
        cnt <= cnt - 1'b1;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Shares the RF write port between writeback and a long-latency unit.
// Optional register scoreboard enabled by macro RF_SCOREBOARD_EN.
module rf_wport_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  lu_valid,
  output logic                  lu_ready,
  input  logic [REG_ADDR_W-1:0] lu_rd,
  input  logic [XLEN-1:0]       lu_data,
  input  logic                  iss_valid,
  input  logic [REG_ADDR_W-1:0] iss_rd,
  input  logic [REG_ADDR_W-1:0] chk_rs1,
  input  logic [REG_ADDR_W-1:0] chk_rs2,
  input  logic [REG_ADDR_W-1:0] chk_rd,
  output logic                  stall,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_a3,
  output logic [XLEN-1:0]       rf_wd
);

  logic  wb_hit;
  logic  fifo_sel;
  logic  push;
  logic  full;
  logic  empty;
  wreq_t head;
  wreq_t din;

  assign wb_hit   = ~reset & wb_we & (wb_rd != '0);
  assign lu_ready = ~reset & ~full;
  assign push     = lu_valid & lu_ready & (lu_rd != '0);
  assign fifo_sel = ~reset & ~empty & ~wb_hit;
  assign din      = '{rd: lu_rd, data: lu_data};

  rf_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (fifo_sel),
    .din   (din),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  // Write-port mux: WB first, else buffered LU head, else idle zeros.
  always_comb begin
    rf_we = 1'b0;
    rf_a3 = '0;
    rf_wd = '0;
    unique case (1'b1)
      wb_hit: begin
        rf_we = 1'b1;
        rf_a3 = wb_rd;
        rf_wd = wb_data;
      end
      fifo_sel: begin
        rf_we = 1'b1;
        rf_a3 = head.rd;
        rf_wd = head.data;
      end
      default: ;
    endcase
  end

`ifdef RF_SCOREBOARD_EN
  logic [31:1] pending;
  logic [31:0] set_m;
  logic [31:0] clr_m;
  logic [31:0] pvec;

  assign set_m = (iss_valid && iss_rd != '0) ? (32'd1 << iss_rd) : '0;
  assign clr_m = fifo_sel ? (32'd1 << head.rd) : '0;
  assign pvec  = {pending, 1'b0};
  assign stall = ~reset &
                 (pvec[chk_rs1] | pvec[chk_rs2] | pvec[chk_rd]);

  // Pending bits: a same-edge set wins over the clear.
  always_ff @(posedge clk) begin
    if (reset)
      pending <= '0;
    else
      pending <= (pending & ~clr_m[31:1]) | set_m[31:1];
  end
`else
  logic unused_sb;
  assign unused_sb = ^{iss_valid, iss_rd, chk_rs1, chk_rs2, chk_rd};
  assign stall     = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Self-checking bench for rf_wport_arbiter.
// Vector table for WB, scripted LU/scoreboard sequences, queue model.
module tb_rf_wport_arbiter;
  import rf_ctrl_pkg::*;

  localparam int DEPTH = 2;
`ifdef RF_SCOREBOARD_EN
  localparam logic SB = 1'b1;
`else
  localparam logic SB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        lu_valid = 1'b0;
  logic        lu_ready;
  logic [4:0]  lu_rd = '0;
  logic [31:0] lu_data = '0;
  logic        iss_valid = 1'b0;
  logic [4:0]  iss_rd = '0;
  logic [4:0]  chk_rs1 = '0;
  logic [4:0]  chk_rs2 = '0;
  logic [4:0]  chk_rd = '0;
  logic        stall;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;

  int checks = 0;
  int errors = 0;

  wreq_t       mq[$];
  logic [31:0] pend = '0;

  rf_wport_arbiter #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .wb_we     (wb_we),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .lu_valid  (lu_valid),
    .lu_ready  (lu_ready),
    .lu_rd     (lu_rd),
    .lu_data   (lu_data),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .chk_rs1   (chk_rs1),
    .chk_rs2   (chk_rs2),
    .chk_rd    (chk_rd),
    .stall     (stall),
    .rf_we     (rf_we),
    .rf_a3     (rf_a3),
    .rf_wd     (rf_wd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n,
                     input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t",
               n, a, e, $time);
    end
  endtask

  // Cycle model: write-port arbitration, FIFO queue, pending bits.
  always @(negedge clk) begin
    logic        exp_rdy;
    logic        wb_act;
    logic        exp_st;
    logic [31:0] clr;
    logic [31:0] set;
    wreq_t       e;
    exp_rdy = !reset && (mq.size() < DEPTH);
    wb_act  = !reset && wb_we && (wb_rd != 0);
    clr = '0;
    chk("m_lu_ready", {31'd0, lu_ready}, {31'd0, exp_rdy});
    if (reset) begin
      chk("m_rst_we", {31'd0, rf_we}, 0);
      chk("m_rst_a3", {27'd0, rf_a3}, 0);
      chk("m_rst_wd", rf_wd, 0);
    end else if (wb_act) begin
      chk("m_wb_we", {31'd0, rf_we}, 1);
      chk("m_wb_a3", {27'd0, rf_a3}, {27'd0, wb_rd});
      chk("m_wb_wd", rf_wd, wb_data);
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      chk("m_lu_we", {31'd0, rf_we}, 1);
      chk("m_lu_a3", {27'd0, rf_a3}, {27'd0, e.rd});
      chk("m_lu_wd", rf_wd, e.data);
      clr[e.rd] = 1'b1;
    end else begin
      chk("m_idle_we", {31'd0, rf_we}, 0);
      chk("m_idle_a3", {27'd0, rf_a3}, 0);
      chk("m_idle_wd", rf_wd, 0);
    end
    if (SB)
      exp_st = !reset &&
               (pend[chk_rs1] || pend[chk_rs2] || pend[chk_rd]);
    else
      exp_st = 1'b0;
    chk("m_stall", {31'd0, stall}, {31'd0, exp_st});
    set = '0;
    if (iss_valid && iss_rd != 0) set[iss_rd] = 1'b1;
    if (reset) begin
      mq.delete();
      pend = '0;
    end else begin
      if (lu_valid && exp_rdy && lu_rd != 0)
        mq.push_back('{rd: lu_rd, data: lu_data});
      pend = (pend & ~clr) | set;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_in();
    wb_we = 0; wb_rd = 0; wb_data = 0;
    lu_valid = 0; lu_rd = 0; lu_data = 0;
    iss_valid = 0; iss_rd = 0;
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        x_we;
    logic [4:0]  x_a3;
    logic [31:0] x_wd;
  } vec_t;

  vec_t vt[6];

  initial begin
    vt[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 5'd5,  32'hDEADBEEF};
    vt[1] = '{1'b1, 5'd0,  32'h00001234, 1'b0, 5'd0,  32'h0};
    vt[2] = '{1'b0, 5'd9,  32'h0000FFFF, 1'b0, 5'd0,  32'h0};
    vt[3] = '{1'b1, 5'd31, 32'hA5A5A5A5, 1'b1, 5'd31, 32'hA5A5A5A5};
    vt[4] = '{1'b1, 5'd1,  32'h00000000, 1'b1, 5'd1,  32'h0};
    vt[5] = '{1'b1, 5'd17, 32'hFFFFFFFF, 1'b1, 5'd17, 32'hFFFFFFFF};

    // Reset: WB request must be ignored.
    wb_we = 1; wb_rd = 5; wb_data = 32'h55;
    smp();
    chk("rst_we", {31'd0, rf_we}, 0);
    chk("rst_ready", {31'd0, lu_ready}, 0);
    chk("rst_stall", {31'd0, stall}, 0);
    step();
    reset = 0;
    idle_in();
    smp();
    chk("ready_after_rst", {31'd0, lu_ready}, 1);

    // WB-only vectors.
    for (int i = 0; i < 6; i++) begin
      step();
      wb_we = vt[i].we; wb_rd = vt[i].rd; wb_data = vt[i].data;
      smp();
      chk($sformatf("vec%0d_we", i), {31'd0, rf_we}, {31'd0, vt[i].x_we});
      chk($sformatf("vec%0d_a3", i), {27'd0, rf_a3}, {27'd0, vt[i].x_a3});
      chk($sformatf("vec%0d_wd", i), rf_wd, vt[i].x_wd);
    end

    // Conflict: LU result waits behind two WB cycles.
    step(); idle_in();
    lu_valid = 1; lu_rd = 7; lu_data = 32'h11;
    step(); idle_in();
    wb_we = 1; wb_rd = 3; wb_data = 32'h33;
    smp(); chk("cf_wb1", {27'd0, rf_a3}, 3);
    step();
    smp(); chk("cf_wb2", {27'd0, rf_a3}, 3);
    step(); idle_in();
    smp();
    chk("cf_we", {31'd0, rf_we}, 1);
    chk("cf_a3", {27'd0, rf_a3}, 7);
    chk("cf_wd", rf_wd, 32'h11);

    // Full FIFO with a held third request.
    step();
    wb_we = 1; wb_rd = 4; wb_data = 32'h44;
    lu_valid = 1; lu_rd = 8; lu_data = 32'h88;
    step(); lu_rd = 9; lu_data = 32'h99;
    step(); lu_rd = 12; lu_data = 32'hCC;
    smp(); chk("full_rdy0", {31'd0, lu_ready}, 0);
    step();
    smp(); chk("full_rdy1", {31'd0, lu_ready}, 0);
    step(); wb_we = 0; wb_rd = 0;
    smp();
    chk("full_x8", {27'd0, rf_a3}, 8);
    chk("full_rdy2", {31'd0, lu_ready}, 0);
    step();
    smp();
    chk("full_x9", {27'd0, rf_a3}, 9);
    chk("full_rdy3", {31'd0, lu_ready}, 1);
    step(); idle_in();
    smp(); chk("full_x12", {27'd0, rf_a3}, 12);
    step();
    smp(); chk("full_idle", {31'd0, rf_we}, 0);

    // x0 handling on both sources.
    step();
    wb_we = 1; wb_rd = 4; wb_data = 32'h44;
    lu_valid = 1; lu_rd = 13; lu_data = 32'hD;
    step(); lu_valid = 0;
    wb_rd = 0; wb_data = 32'hBAD;
    smp();
    chk("x0_wb_a3", {27'd0, rf_a3}, 13);
    chk("x0_wb_wd", rf_wd, 32'hD);
    step(); idle_in();
    lu_valid = 1; lu_rd = 0; lu_data = 32'hEE;
    smp(); chk("x0_lu_rdy", {31'd0, lu_ready}, 1);
    step(); idle_in();
    smp(); chk("x0_lu_we1", {31'd0, rf_we}, 0);
    step();
    smp(); chk("x0_lu_we2", {31'd0, rf_we}, 0);

    // Scoreboard: set, hold until write, clear afterwards.
    step(); iss_valid = 1; iss_rd = 10; chk_rs2 = 10;
    smp(); chk("sb_pre", {31'd0, stall}, 0);
    step(); iss_valid = 0;
    smp(); chk("sb_set", {31'd0, stall}, {31'd0, SB});
    step();
    wb_we = 1; wb_rd = 4; wb_data = 32'h44;
    lu_valid = 1; lu_rd = 10; lu_data = 32'hA0;
    smp(); chk("sb_hold1", {31'd0, stall}, {31'd0, SB});
    step(); lu_valid = 0;
    smp(); chk("sb_hold2", {31'd0, stall}, {31'd0, SB});
    step(); idle_in();
    smp();
    chk("sb_wr_a3", {27'd0, rf_a3}, 10);
    chk("sb_wr_st", {31'd0, stall}, {31'd0, SB});
    step();
    smp(); chk("sb_clr", {31'd0, stall}, 0);

    // Scoreboard: reissue on the clear edge keeps the bit.
    step(); iss_valid = 1; iss_rd = 10;
    step(); iss_valid = 0;
    wb_we = 1; wb_rd = 4;
    lu_valid = 1; lu_rd = 10; lu_data = 32'hA1;
    step(); idle_in();
    iss_valid = 1; iss_rd = 10;
    smp();
    chk("sb_re_a3", {27'd0, rf_a3}, 10);
    chk("sb_re_st", {31'd0, stall}, {31'd0, SB});
    step(); idle_in();
    smp(); chk("sb_re_keep", {31'd0, stall}, {31'd0, SB});
    step(); lu_valid = 1; lu_rd = 10; lu_data = 32'hA2;
    step(); idle_in();
    smp(); chk("sb_re_wr", {27'd0, rf_a3}, 10);
    step();
    smp(); chk("sb_re_clr", {31'd0, stall}, 0);
    chk_rs2 = 0;

    // Reset mid-operation drops buffered entries and pending bits.
    step();
    wb_we = 1; wb_rd = 4; wb_data = 32'h44;
    lu_valid = 1; lu_rd = 20; lu_data = 32'h20;
    iss_valid = 1; iss_rd = 25; chk_rd = 25;
    step(); lu_rd = 21; lu_data = 32'h21; iss_valid = 0;
    step(); lu_valid = 0; reset = 1;
    smp();
    chk("mr_we", {31'd0, rf_we}, 0);
    chk("mr_st", {31'd0, stall}, 0);
    step(); reset = 0; idle_in();
    smp();
    chk("mr_rdy", {31'd0, lu_ready}, 1);
    chk("mr_st2", {31'd0, stall}, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      smp(); chk($sformatf("mr_nowr%0d", i), {31'd0, rf_we}, 0);
    end
    chk_rd = 0;

    // Randomised LU/WB traffic against the queue model.
    for (int i = 0; i < 300; i++) begin
      step();
      wb_we    = ($urandom_range(0, 2) == 0);
      wb_rd    = 5'($urandom_range(0, 31));
      wb_data  = $urandom;
      lu_valid = $urandom_range(0, 1) == 1;
      lu_rd    = 5'($urandom_range(0, 31));
      lu_data  = $urandom;
      iss_valid = $urandom_range(0, 3) == 0;
      iss_rd   = 5'($urandom_range(0, 31));
      chk_rs1  = 5'($urandom_range(0, 31));
      chk_rs2  = 5'($urandom_range(0, 31));
      chk_rd   = 5'($urandom_range(0, 31));
    end
    step(); idle_in();
    for (int i = 0; i < 6; i++) step();
    smp();
    chk("drain_we", {31'd0, rf_we}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
